// File: rtl/window3x3_max.sv
// window3x3_max
// -----------------------------------------------------------------------------
// Consumer end of a 3x3 line buffer. Three row-aligned pixel streams (newest,
// centre, oldest row) are assembled column by column into a 3x3 window. The
// block emits one registered stream of 3x3 maxima (grey dilation). It
// regenerates tuser/tlast and applies the image-border rules.
//
// Ports
//   s_axis_aclk            clock
//   srst                   synchronous active-high reset
//   s_axis_line_0_*        bottom (newest) row; only tdata is used
//   s_axis_line_1_*        centre row; tvalid accepts a column, tuser/tlast frame it
//   s_axis_line_2_*        top (oldest) row; only tdata is used
//   m_axis_tdata           3x3 maximum
//   m_axis_tuser           first pixel of frame
//   m_axis_tlast           last pixel of row
//   m_axis_tvalid          output strobe (no backpressure)
//
// Handshake: an input column is taken on every cycle with
// s_axis_line_1_tvalid=1 (no ready; the block always accepts). An output is
// valid for exactly the cycle m_axis_tvalid=1, and downstream always takes it.
//
// Build option: define BORDER_ZERO_EN to force every output whose window
// touches an out-of-image position to 0. When it is undefined, out-of-image
// samples are replaced by the centre pixel, which gives the max over in-image
// samples only.
// -----------------------------------------------------------------------------
module window3x3_max #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  s_axis_aclk,
  input  logic                  srst,
  input  logic [DATA_WIDTH-1:0] s_axis_line_0_tdata,
  input  logic                  s_axis_line_0_tlast,
  input  logic                  s_axis_line_0_tuser,
  input  logic                  s_axis_line_0_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_line_1_tdata,
  input  logic                  s_axis_line_1_tlast,
  input  logic                  s_axis_line_1_tuser,
  input  logic                  s_axis_line_1_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_line_2_tdata,
  input  logic                  s_axis_line_2_tlast,
  input  logic                  s_axis_line_2_tuser,
  input  logic                  s_axis_line_2_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid
);

  localparam int RW = $clog2(IMG_HEIGHT + 1);
  localparam logic [RW-1:0] ROW_SAT  = RW'(IMG_HEIGHT);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  // Row length comes from tlast on the centre stream. IMG_WIDTH only describes
  // the expected stream.
  localparam int unused_img_width = IMG_WIDTH;

  // The outer rows are aligned to the centre row, so their framing bits are
  // redundant.
  logic unused_inputs;
  assign unused_inputs = ^{s_axis_line_0_tlast, s_axis_line_0_tuser, s_axis_line_0_tvalid,
                           s_axis_line_2_tlast, s_axis_line_2_tuser, s_axis_line_2_tvalid};

  // Column A (older) and column B (newer). Each column holds top/mid/bottom
  // pixels. A's tuser is never needed because outputs are always centred on B.
  logic [DATA_WIDTH-1:0] a_top_q, a_top_d, a_mid_q, a_mid_d, a_bot_q, a_bot_d;
  logic [DATA_WIDTH-1:0] b_top_q, b_top_d, b_mid_q, b_mid_d, b_bot_q, b_bot_d;
  logic                  a_valid_q, a_valid_d, b_valid_q, b_valid_d, b_user_q, b_user_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [RW-1:0]         row_cnt_q, row_cnt_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  m_tuser_q, m_tuser_d, m_tlast_q, m_tlast_d, m_tvalid_q, m_tvalid_d;

  // Window around B: column 0 = A, 1 = B, 2 = incoming column. Row 0 is the
  // top row and row 2 is the bottom row.
  logic [2:0]            col_ok, row_ok;
  logic [DATA_WIDTH-1:0] win [3][3];
  logic [DATA_WIDTH-1:0] samp, win_max;
`ifdef BORDER_ZERO_EN
  logic                  any_out;
`endif

  always_comb begin
    // During a flush the right column lies past the row end.
    col_ok = {!flush_pend_q, 1'b1, a_valid_q};
    row_ok = {row_cnt_q != ROW_LAST, 1'b1, row_cnt_q != '0};
    win[0][0] = a_top_q;             win[0][1] = a_mid_q;             win[0][2] = a_bot_q;
    win[1][0] = b_top_q;             win[1][1] = b_mid_q;             win[1][2] = b_bot_q;
    win[2][0] = s_axis_line_2_tdata; win[2][1] = s_axis_line_1_tdata; win[2][2] = s_axis_line_0_tdata;
    win_max = '0;
    samp    = '0;
`ifdef BORDER_ZERO_EN
    any_out = 1'b0;
`endif
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        // The centre pixel is always in-image, so substituting it for
        // out-of-image samples leaves the max over in-image samples.
        samp = (col_ok[c] && row_ok[r]) ? win[c][r] : b_mid_q;
        if (samp > win_max) win_max = samp;
`ifdef BORDER_ZERO_EN
        if (!(col_ok[c] && row_ok[r])) any_out = 1'b1;
`endif
      end
    end
`ifdef BORDER_ZERO_EN
    if (any_out) win_max = '0;
`endif
  end

  logic [RW-1:0] row_next;
  logic          take;

  always_comb begin
    a_top_d = a_top_q; a_mid_d = a_mid_q; a_bot_d = a_bot_q; a_valid_d = a_valid_q;
    b_top_d = b_top_q; b_mid_d = b_mid_q; b_bot_d = b_bot_q; b_valid_d = b_valid_q;
    b_user_d     = b_user_q;
    flush_pend_d = flush_pend_q;
    m_tdata_d    = '0;
    m_tuser_d    = 1'b0;
    m_tlast_d    = 1'b0;
    m_tvalid_d   = 1'b0;

    // Row count after this cycle's flush. Drop decisions use it so that a
    // column arriving in the flush of the last row is already past the frame.
    row_next = row_cnt_q;
    if (flush_pend_q && row_cnt_q != ROW_SAT) row_next = row_cnt_q + 1'b1;
    take = s_axis_line_1_tvalid && (s_axis_line_1_tuser || row_next != ROW_SAT);

    if ((flush_pend_q || take) && b_valid_q) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = win_max;
      m_tuser_d  = b_user_q;
      m_tlast_d  = flush_pend_q;
    end

    if (flush_pend_q) begin
      flush_pend_d = 1'b0;
      a_valid_d    = 1'b0;
      b_valid_d    = 1'b0;
    end

    if (take) begin
      // After a flush the new column starts a row, so A stays empty.
      if (b_valid_q && !flush_pend_q) begin
        a_top_d = b_top_q; a_mid_d = b_mid_q; a_bot_d = b_bot_q;
        a_valid_d = 1'b1;
      end else begin
        a_valid_d = 1'b0;
      end
      b_top_d      = s_axis_line_2_tdata;
      b_mid_d      = s_axis_line_1_tdata;
      b_bot_d      = s_axis_line_0_tdata;
      b_valid_d    = 1'b1;
      b_user_d     = s_axis_line_1_tuser;
      flush_pend_d = s_axis_line_1_tlast;
    end

    // Start of frame overrides the flush increment.
    row_cnt_d = (take && s_axis_line_1_tuser) ? '0 : row_next;
  end

  always_ff @(posedge s_axis_aclk) begin
    if (srst) begin
      a_valid_q    <= 1'b0;
      b_valid_q    <= 1'b0;
      b_user_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      row_cnt_q    <= ROW_SAT;
      m_tdata_q    <= '0;
      m_tuser_q    <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tvalid_q   <= 1'b0;
    end else begin
      a_valid_q    <= a_valid_d;
      b_valid_q    <= b_valid_d;
      b_user_q     <= b_user_d;
      flush_pend_q <= flush_pend_d;
      row_cnt_q    <= row_cnt_d;
      m_tdata_q    <= m_tdata_d;
      m_tuser_q    <= m_tuser_d;
      m_tlast_q    <= m_tlast_d;
      m_tvalid_q   <= m_tvalid_d;
    end
    // Pixel storage is qualified by the valid flags and needs no reset.
    a_top_q <= a_top_d; a_mid_q <= a_mid_d; a_bot_q <= a_bot_d;
    b_top_q <= b_top_d; b_mid_q <= b_mid_d; b_bot_q <= b_bot_d;
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tuser  = m_tuser_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tvalid = m_tvalid_q;

endmodule
